// File: rtl/csr_trap_seq_if.sv
// Handshake and CSR write-port bundle between the pipeline, the trap
// sequencer and the machine-mode CSR file.
interface csr_trap_seq_if;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_req;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mstatus;
  logic        pipe_wren;
  logic [11:0] pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        wren;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        trap_ack;
  logic        stall;
  logic        flush;
  logic        jmp_do;
  logic [31:0] jmp_pc;
  logic        busy;

  modport slave (
    input  trap_req, trap_cause, trap_pc, trap_tval, mret_req,
    input  csr_mtvec, csr_mepc, csr_mstatus,
    input  pipe_wren, pipe_waddr, pipe_wdata,
    output wren, waddr, wdata, trap_ack, stall, flush, jmp_do, jmp_pc, busy
  );

  modport master (
    output trap_req, trap_cause, trap_pc, trap_tval, mret_req,
    output csr_mtvec, csr_mepc, csr_mstatus,
    output pipe_wren, pipe_waddr, pipe_wdata,
    input  wren, waddr, wdata, trap_ack, stall, flush, jmp_do, jmp_pc, busy
  );
endinterface

// File: rtl/csr_trap_seq.sv
// Trap/mret sequencer owning the CSR file write port: passes pipeline writes
// through when idle, otherwise issues the trap/mret CSR updates and redirects fetch.
module csr_trap_seq (
  input  logic           clk_i,
  input  logic           rst_ni,
  csr_trap_seq_if.slave  seq_if
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_T_MEPC    = 3'd1,
    S_T_MCAUSE  = 3'd2,
    S_T_MTVAL   = 3'd3,
    S_T_MSTATUS = 3'd4,
    S_R_MSTATUS = 3'd5,
    S_REDIRECT  = 3'd6
  } state_e;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] jmp_pc_q, jmp_pc_d;
  logic        wren_s;
  logic [11:0] waddr_s;
  logic [31:0] wdata_s;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Vectored mode only applies to interrupts; exceptions always use the base.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] base;
    base = mtvec & ALIGN_MASK;
    if ((mtvec[1:0] == 2'b01) && cause[31]) begin
      return base + {cause[29:0], 2'b00};
    end else begin
      return base;
    end
  endfunction

  // State, latched trap payload and redirect target registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cause_q  <= 32'h0;
      pc_q     <= 32'h0;
      tval_q   <= 32'h0;
      jmp_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      pc_q     <= pc_d;
      tval_q   <= tval_d;
      jmp_pc_q <= jmp_pc_d;
    end
  end

  // Next-state, write-port mux and redirect-target capture.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    pc_d     = pc_q;
    tval_d   = tval_q;
    jmp_pc_d = jmp_pc_q;
    wren_s   = 1'b0;
    waddr_s  = 12'h0;
    wdata_s  = 32'h0;
    case (state_q)
      S_IDLE: begin
        // The accept-cycle pipeline write is older than the trap and still commits.
        wren_s  = seq_if.pipe_wren;
        waddr_s = seq_if.pipe_waddr;
        wdata_s = seq_if.pipe_wdata;
        if (seq_if.trap_req) begin
          cause_d = seq_if.trap_cause;
          pc_d    = seq_if.trap_pc;
          tval_d  = seq_if.trap_tval;
          state_d = S_T_MEPC;
        end else if (seq_if.mret_req) begin
          state_d = S_R_MSTATUS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T_MEPC: begin
        wren_s  = 1'b1;
        waddr_s = ADDR_MEPC;
        wdata_s = pc_q & ALIGN_MASK;
        state_d = S_T_MCAUSE;
      end
      S_T_MCAUSE: begin
        wren_s  = 1'b1;
        waddr_s = ADDR_MCAUSE;
        wdata_s = cause_q;
        state_d = S_T_MTVAL;
      end
      S_T_MTVAL: begin
        wren_s  = 1'b1;
        waddr_s = ADDR_MTVAL;
        wdata_s = tval_q;
        state_d = S_T_MSTATUS;
      end
      S_T_MSTATUS: begin
        wren_s   = 1'b1;
        waddr_s  = ADDR_MSTATUS;
        wdata_s  = trap_mstatus(seq_if.csr_mstatus);
        jmp_pc_d = trap_target(seq_if.csr_mtvec, cause_q);
        state_d  = S_REDIRECT;
      end
      S_R_MSTATUS: begin
        wren_s   = 1'b1;
        waddr_s  = ADDR_MSTATUS;
        wdata_s  = mret_mstatus(seq_if.csr_mstatus);
        jmp_pc_d = seq_if.csr_mepc & ALIGN_MASK;
        state_d  = S_REDIRECT;
      end
      S_REDIRECT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pass-through is gated by reset so nothing reaches the CSR file while rst_ni is low.
  assign seq_if.wren     = rst_ni & wren_s;
  assign seq_if.waddr    = rst_ni ? waddr_s : 12'h0;
  assign seq_if.wdata    = rst_ni ? wdata_s : 32'h0;
  assign seq_if.trap_ack = (state_q == S_T_MEPC) || (state_q == S_R_MSTATUS);
  assign seq_if.stall    = (state_q != S_IDLE);
  assign seq_if.busy     = (state_q != S_IDLE);
  assign seq_if.flush    = (state_q == S_REDIRECT);
  assign seq_if.jmp_do   = (state_q == S_REDIRECT);
  assign seq_if.jmp_pc   = jmp_pc_q;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Self-checking bench for csr_trap_seq: a transaction-level model predicts every
// cycle's outputs while directed and random traffic drives a small CSR file.
module tb_csr_trap_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csr_trap_seq_if bus();

  csr_trap_seq dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .seq_if (bus.slave)
  );

  // CSR file environment: synchronous write, combinational read.
  logic [31:0] mtvec_r   = 32'h0;
  logic [31:0] mepc_r    = 32'h0;
  logic [31:0] mstatus_r = 32'h0;
  logic [31:0] mcause_r  = 32'h0;
  logic [31:0] mtval_r   = 32'h0;
  assign bus.csr_mtvec   = mtvec_r;
  assign bus.csr_mepc    = mepc_r;
  assign bus.csr_mstatus = mstatus_r;

  always @(posedge clk) begin
    if (bus.wren) begin
      case (bus.waddr)
        12'h300: mstatus_r <= bus.wdata;
        12'h305: mtvec_r   <= bus.wdata;
        12'h341: mepc_r    <= bus.wdata;
        12'h342: mcause_r  <= bus.wdata;
        12'h343: mtval_r   <= bus.wdata;
        default: ;
      endcase
    end
  end

  // Model: each accepted request becomes a list of per-cycle steps.
  // kind 0 = fixed write, 1 = trap mstatus, 2 = mret mstatus, 3 = trap jump, 4 = mret jump
  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] data;
    bit          ack;
  } step_t;

  step_t       q[$];
  logic [31:0] m_mtvec = 32'h0, m_mepc = 32'h0, m_mstatus = 32'h0;
  logic [31:0] m_jmp = 32'h0;
  bit          e_wren, e_busy, e_ack, e_redir, acc_trap, acc_mret;
  logic [11:0] e_addr;
  logic [31:0] e_data;
  bit          hold_req = 1'b0;
  int          n_vec = 0, n_err = 0, ack_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ms_trap(input logic [31:0] x);
    return (x & ~32'h0000_0088) | 32'h0000_1800 | (x[3] ? 32'h0000_0080 : 32'h0);
  endfunction

  function automatic logic [31:0] ms_mret(input logic [31:0] x);
    return (x & ~32'h0000_0008) | 32'h0000_1880 | (x[7] ? 32'h0000_0008 : 32'h0);
  endfunction

  function automatic logic [31:0] vec_pc(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] base;
    base = mtvec - (mtvec % 32'd4);
    if ((mtvec % 32'd4 == 32'd1) && cause[31]) return base + (cause & 32'h3FFF_FFFF) * 32'd4;
    return base;
  endfunction

  task automatic push_step(input int k, input logic [11:0] a, input logic [31:0] d, input bit ack);
    step_t s;
    s.kind = k; s.addr = a; s.data = d; s.ack = ack;
    q.push_back(s);
  endtask

  task automatic model_expect();
    acc_trap = 1'b0; acc_mret = 1'b0;
    e_ack = 1'b0; e_redir = 1'b0;
    if (q.size() == 0) begin
      e_busy = 1'b0;
      e_wren = bus.pipe_wren; e_addr = bus.pipe_waddr; e_data = bus.pipe_wdata;
      if (bus.trap_req) acc_trap = 1'b1;
      else if (bus.mret_req) acc_mret = 1'b1;
    end else begin
      e_busy = 1'b1; e_ack = q[0].ack; e_wren = 1'b1;
      e_addr = q[0].addr; e_data = q[0].data;
      case (q[0].kind)
        0: ;
        1: e_data = ms_trap(m_mstatus);
        2: e_data = ms_mret(m_mstatus);
        3: begin e_wren = 1'b0; e_redir = 1'b1; m_jmp = vec_pc(m_mtvec, q[0].data); end
        default: begin e_wren = 1'b0; e_redir = 1'b1; m_jmp = m_mepc & 32'hFFFF_FFFC; end
      endcase
    end
  endtask

  task automatic model_advance();
    if (e_wren) begin
      case (e_addr)
        12'h300: m_mstatus = e_data;
        12'h305: m_mtvec   = e_data;
        12'h341: m_mepc    = e_data;
        default: ;
      endcase
    end
    if (q.size() != 0) begin
      q.delete(0);
    end else if (acc_trap) begin
      push_step(0, 12'h341, bus.trap_pc & 32'hFFFF_FFFC, 1'b1);
      push_step(0, 12'h342, bus.trap_cause, 1'b0);
      push_step(0, 12'h343, bus.trap_tval, 1'b0);
      push_step(1, 12'h300, 32'h0, 1'b0);
      push_step(3, 12'h000, bus.trap_cause, 1'b0);
      if (!hold_req) bus.trap_req = 1'b0;
    end else if (acc_mret) begin
      push_step(2, 12'h300, 32'h0, 1'b1);
      push_step(4, 12'h000, 32'h0, 1'b0);
      if (!hold_req) bus.mret_req = 1'b0;
    end
  endtask

  // One clock: predict and compare at the falling edge, then advance after the rising edge.
  task automatic step();
    @(negedge clk);
    model_expect();
    chk("wren", bus.wren, e_wren);
    if (e_wren || !e_busy) begin
      chk("waddr", bus.waddr, e_addr);
      chk("wdata", bus.wdata, e_data);
    end
    chk("trap_ack", bus.trap_ack, e_ack);
    chk("stall", bus.stall, e_busy);
    chk("busy", bus.busy, e_busy);
    chk("flush", bus.flush, e_redir);
    chk("jmp_do", bus.jmp_do, e_redir);
    chk("jmp_pc", bus.jmp_pc, m_jmp);
    if (bus.trap_ack) ack_cnt++;
    @(posedge clk);
    #1;
    model_advance();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wren"}, bus.wren, 32'h0);
    chk({tag, "_waddr"}, bus.waddr, 32'h0);
    chk({tag, "_wdata"}, bus.wdata, 32'h0);
    chk({tag, "_ack"}, bus.trap_ack, 32'h0);
    chk({tag, "_stall"}, bus.stall, 32'h0);
    chk({tag, "_flush"}, bus.flush, 32'h0);
    chk({tag, "_jmp_do"}, bus.jmp_do, 32'h0);
    chk({tag, "_jmp_pc"}, bus.jmp_pc, 32'h0);
    chk({tag, "_busy"}, bus.busy, 32'h0);
  endtask

  task automatic pipe_wr(input logic [11:0] a, input logic [31:0] d);
    bus.pipe_wren = 1'b1; bus.pipe_waddr = a; bus.pipe_wdata = d;
    step();
    bus.pipe_wren = 1'b0;
  endtask

  task automatic raise_trap(input logic [31:0] c, input logic [31:0] pc, input logic [31:0] tv);
    bus.trap_req = 1'b1; bus.trap_cause = c; bus.trap_pc = pc; bus.trap_tval = tv;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_inputs();
    bus.pipe_wren  = ($urandom % 3 == 0);
    bus.pipe_wdata = $urandom;
    case ($urandom % 6)
      0: bus.pipe_waddr = 12'h300;
      1: bus.pipe_waddr = 12'h305;
      2: bus.pipe_waddr = 12'h341;
      3: bus.pipe_waddr = 12'h342;
      4: bus.pipe_waddr = 12'h343;
      default: bus.pipe_waddr = 12'($urandom);
    endcase
    if (!bus.trap_req && ($urandom % 8 == 0)) begin
      raise_trap({1'($urandom), 31'($urandom % 64)}, $urandom, $urandom);
    end
    if (!bus.mret_req && ($urandom % 9 == 0)) bus.mret_req = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.trap_req = 1'b0; bus.mret_req = 1'b0;
    bus.trap_cause = 32'h0; bus.trap_pc = 32'h0; bus.trap_tval = 32'h0;
    bus.pipe_wren = 1'b1; bus.pipe_waddr = 12'h342; bus.pipe_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk_all_zero("rst");
    bus.pipe_wren = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Direct-mode exception.
    pipe_wr(12'h305, 32'h0000_1000);
    pipe_wr(12'h300, 32'h0000_0008);
    raise_trap(32'h2, 32'h80, 32'hDEAD_BEEF);
    run(7);
    chk("d_mepc", mepc_r, 32'h0000_0080);
    chk("d_mcause", mcause_r, 32'h0000_0002);
    chk("d_mtval", mtval_r, 32'hDEAD_BEEF);
    chk("d_mstatus", mstatus_r, 32'h0000_1880);
    chk("d_jmp_pc", bus.jmp_pc, 32'h0000_1000);

    // Vectored interrupt, then exception under the same vector.
    pipe_wr(12'h305, 32'h0000_2001);
    raise_trap(32'h8000_0007, 32'h200, 32'h0);
    run(7);
    chk("v_irq_jmp", bus.jmp_pc, 32'h0000_201C);
    raise_trap(32'h0000_0007, 32'h204, 32'h0);
    run(7);
    chk("v_exc_jmp", bus.jmp_pc, 32'h0000_2000);

    // mret.
    pipe_wr(12'h300, 32'h0000_1880);
    pipe_wr(12'h341, 32'h0000_0123);
    bus.mret_req = 1'b1;
    run(4);
    chk("m_mstatus", mstatus_r, 32'h0000_1888);
    chk("m_jmp_pc", bus.jmp_pc, 32'h0000_0120);

    // Trap and mret together: trap wins, mret follows once idle.
    raise_trap(32'h0000_000B, 32'h300, 32'h0);
    bus.mret_req = 1'b1;
    run(6);
    chk("both_mcause", mcause_r, 32'h0000_000B);
    run(4);

    // Accept-cycle pipeline write commits; in-sequence writes are dropped.
    raise_trap(32'h5, 32'h400, 32'h1);
    bus.pipe_wren = 1'b1; bus.pipe_waddr = 12'h300; bus.pipe_wdata = 32'h0000_0088;
    step();
    bus.pipe_waddr = 12'h305; bus.pipe_wdata = 32'hFFFF_FFFF;
    run(5);
    bus.pipe_wren = 1'b0;
    run(1);
    chk("acc_mstatus", mstatus_r, 32'h0000_1880);
    chk("seq_mtvec", mtvec_r, 32'h0000_2001);

    // Request held through REDIRECT re-triggers at the first idle cycle.
    ack_cnt = 0;
    hold_req = 1'b1;
    raise_trap(32'h3, 32'h500, 32'h2);
    run(6);
    hold_req = 1'b0;
    run(7);
    chk("b2b_acks", ack_cnt, 32'd2);

    // Reset during T_MCAUSE aborts the sequence; the mepc write stays.
    raise_trap(32'h4, 32'h0000_0604, 32'h3);
    run(2);
    #2;
    rst_n = 1'b0;
    bus.pipe_wren = 1'b1; bus.pipe_waddr = 12'h343; bus.pipe_wdata = 32'h5555_5555;
    #1;
    chk_all_zero("mid_rst");
    q.delete();
    m_jmp = 32'h0;
    bus.pipe_wren = 1'b0;
    bus.trap_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mepc", mepc_r, 32'h0000_0604);
    chk("rst_mtval", mtval_r, 32'h0000_0002);
    pipe_wr(12'h343, 32'hA5A5_0001);
    run(1);
    chk("rst_pass", mtval_r, 32'hA5A5_0001);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      step();
    end
    bus.trap_req = 1'b0; bus.mret_req = 1'b0; bus.pipe_wren = 1'b0;
    run(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
